// File: rtl/tdm_demux4_pkg.sv
// Shared constants and types for the 4-slot TDM receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a; slot constants match the transmit-side select generator.
package tdm_demux4_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  // Framing FSM: hunting for slot 0, or slots 1..3 still pending.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bundle of the serial TDM beat input and the parallel per-channel outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the link side stalls by dropping din_valid.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  import tdm_demux4_pkg::*;

  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              frame_start;
  logic [WIDTH-1:0]  ch0;
  logic [WIDTH-1:0]  ch1;
  logic [WIDTH-1:0]  ch2;
  logic [WIDTH-1:0]  ch3;
  logic              frame_valid;
  logic              frame_err;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        frame_cnt;

  // Link/test side: drives beats, observes decoded frames.
  modport master (
    output din, din_valid, frame_start,
    input  ch0, ch1, ch2, ch3, frame_valid, frame_err, slot, frame_cnt
  );

  // Demux side: consumes beats, presents decoded frames.
  modport slave (
    input  din, din_valid, frame_start,
    output ch0, ch1, ch2, ch3, frame_valid, frame_err, slot, frame_cnt
  );

endinterface

// File: rtl/tdm_demux4.sv
// Aligns on frame_start, gathers 4 valid beats, updates ch0..ch3 together once per frame.
// Latency: outputs valid one edge after the slot-3 beat is sampled; no bubble between frames.
// Backpressure: none; din_valid low holds all state indefinitely.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);
  import tdm_demux4_pkg::*;

  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [WIDTH-1:0]  r_shadow0;
  logic [WIDTH-1:0]  r_shadow1;
  logic [WIDTH-1:0]  r_shadow2;
  logic [WIDTH-1:0]  r_ch0;
  logic [WIDTH-1:0]  r_ch1;
  logic [WIDTH-1:0]  r_ch2;
  logic [WIDTH-1:0]  r_ch3;
  logic              r_frame_valid;
  logic              r_frame_err;
  logic [7:0]        r_frame_cnt;

  logic              w_beat;
  logic              w_sof;

  assign w_beat = bus.din_valid;
  assign w_sof  = bus.din_valid & bus.frame_start;

  // Framing FSM, slot counter, shadow capture and atomic output-bank update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_slot        <= SLOT0;
      r_shadow0     <= '0;
      r_shadow1     <= '0;
      r_shadow2     <= '0;
      r_ch0         <= '0;
      r_ch1         <= '0;
      r_ch2         <= '0;
      r_ch3         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_sof) begin
        // A marker always restarts the frame; mid-frame (including on slot 3)
        // it is a violation and the partial frame is dropped.
        r_frame_err <= (r_state == ST_COLLECT);
        r_shadow0   <= bus.din;
        r_slot      <= SLOT1;
        r_state     <= ST_COLLECT;
      end else if (w_beat && (r_state == ST_COLLECT)) begin
        case (r_slot)
          SLOT1: begin
            r_shadow1 <= bus.din;
            r_slot    <= SLOT2;
          end
          SLOT2: begin
            r_shadow2 <= bus.din;
            r_slot    <= SLOT3;
          end
          SLOT3: begin
            // Slot 3 bypasses the shadow so the whole bank lands on one edge.
            r_ch0         <= r_shadow0;
            r_ch1         <= r_shadow1;
            r_ch2         <= r_shadow2;
            r_ch3         <= bus.din;
            r_frame_valid <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 8'd1;
            r_slot        <= SLOT0;
            r_state       <= ST_IDLE;
          end
          default: begin
            // Slot 0 never occurs while collecting; resynchronise defensively.
            r_slot  <= SLOT0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ch0         = r_ch0;
  assign bus.ch1         = r_ch1;
  assign bus.ch2         = r_ch2;
  assign bus.ch3         = r_ch3;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.slot        = r_slot;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule
